// File: rtl/kbd_scan_sequencer_if.sv
// rtl/kbd_scan_sequencer_if.sv - byte input and key-event FIFO bundle for the PS/2 set-2 sequencer
interface kbd_scan_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic [7:0]        evt_code;
  logic              evt_brk;
  logic              evt_ext;
  logic              evt_valid;
  logic              evt_ready;
  logic [FCNT_W-1:0] fifo_count;
  logic              overflow;
  logic              protocol_err;

  modport master (
    output byte_in, byte_valid, evt_ready,
    input  evt_code, evt_brk, evt_ext, evt_valid, fifo_count, overflow, protocol_err
  );

  modport slave (
    input  byte_in, byte_valid, evt_ready,
    output evt_code, evt_brk, evt_ext, evt_valid, fifo_count, overflow, protocol_err
  );
endinterface

// File: rtl/kbd_scan_sequencer.sv
// rtl/kbd_scan_sequencer.sv - folds E0/F0/E1 prefixes into {ext,brk,code} events queued in a show-ahead FIFO
module kbd_scan_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input logic                  clk,
  input logic                  reset,
  kbd_scan_sequencer_if.slave  bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_E0,
    S_GOT_F0,
    S_GOT_E0F0,
    S_SKIP_E1
  } state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [2:0]       skip_q, skip_d;
  logic             err_q, err_d;
  logic             push;
  evt_t             push_evt;
  logic             is_ctrl;

  always_comb begin
    is_ctrl = 1'b0;
    unique case (bus.byte_in)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                  is_ctrl = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      skip_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    skip_d   = skip_q;
    err_d    = 1'b0;
    push     = 1'b0;
    push_evt = '0;
    if (bus.byte_valid) begin
      if (state_q == S_SKIP_E1) begin
        // The pause payload is opaque, so even control-looking bytes count down.
        tmo_d  = '0;
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          push     = 1'b1;
          push_evt = '{ext: 1'b0, brk: 1'b0, code: 8'hE1};
          state_d  = S_IDLE;
        end
      end else if (!is_ctrl) begin
        tmo_d = '0;
        if (bus.byte_in == 8'hE1) begin
          state_d = S_SKIP_E1;
          skip_d  = 3'd7;
        end else begin
          unique case (state_q)
            S_IDLE: begin
              if (bus.byte_in == 8'hE0)      state_d = S_GOT_E0;
              else if (bus.byte_in == 8'hF0) state_d = S_GOT_F0;
              else begin
                push     = 1'b1;
                push_evt = '{ext: 1'b0, brk: 1'b0, code: bus.byte_in};
              end
            end
            S_GOT_E0: begin
              if (bus.byte_in == 8'hF0)      state_d = S_GOT_E0F0;
              else if (bus.byte_in != 8'hE0) begin
                push     = 1'b1;
                push_evt = '{ext: 1'b1, brk: 1'b0, code: bus.byte_in};
                state_d  = S_IDLE;
              end
            end
            S_GOT_F0, S_GOT_E0F0: begin
              state_d = S_IDLE;
              if (bus.byte_in == 8'hE0 || bus.byte_in == 8'hF0) begin
                err_d = 1'b1;
              end else begin
                push     = 1'b1;
                push_evt = '{ext: (state_q == S_GOT_E0F0), brk: 1'b1, code: bus.byte_in};
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [FCNT_W-1:0] count_q;
  logic              ovf_q;
  evt_t              hold_q;
  evt_t              mem_q [FIFO_DEPTH];
  evt_t              head;
  logic              empty, full, pop, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = !empty && bus.evt_ready;
  assign wr_en = push && (!full || pop);
  // hold_q keeps the last popped entry so the fields stay put once the FIFO drains.
  assign head  = empty ? hold_q : mem_q[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        hold_q <= head;
      end
      if (wr_en) wr_q <= wr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_evt;
  end

  assign bus.evt_code     = head.code;
  assign bus.evt_brk      = head.brk;
  assign bus.evt_ext      = head.ext;
  assign bus.evt_valid    = !empty;
  assign bus.fifo_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.protocol_err = err_q;

endmodule
